// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the KGPRISC instruction-fetch stage: widths, FSM encoding
// and the issue-credit helper.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int INSTR_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // A new read may go out only if it can never overflow the 2-entry queue.
  function automatic logic issue_ok(input logic [1:0] count, input logic inflight,
                                    input logic pop);
    return (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  endfunction

endpackage

// File: rtl/fetch_unit_fifo2.sv
// Two-entry FIFO of {pc, instr}; slot0 is always the head.
// Supports push, pop and flush, with push and pop in the same cycle.
module fetch_unit_fifo2 #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_r, slot1_r, slot0_s, slot1_s;
  logic [1:0]   count_r, count_s;

  // next slot contents and occupancy
  always_comb begin
    slot0_s = slot0_r;
    slot1_s = slot1_r;
    count_s = count_r;
    if (flush) begin
      count_s = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) slot0_s = wdata;
          else                 slot1_s = wdata;
          count_s = count_r + 2'd1;
        end
        2'b01: begin
          slot0_s = slot1_r;
          count_s = count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_s = wdata;
          end else begin
            slot0_s = slot1_r;
            slot1_s = wdata;
          end
        end
        default: count_s = count_r;
      endcase
    end
  end

  // storage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0_r <= {W{1'b0}};
      slot1_r <= {W{1'b0}};
      count_r <= 2'd0;
    end else begin
      slot0_r <= slot0_s;
      slot1_r <= slot1_s;
      count_r <= count_s;
    end
  end

  assign head  = slot0_r;
  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// KGPRISC instruction-fetch stage: PC, issue to a 1-cycle synchronous imem,
// 2-entry return queue, redirect/flush and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               halted
);

  localparam int ENT_W = ADDR_W + INSTR_W;

  fetch_state_e      state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s, inflight_pc_r;
  logic              inflight_r, halt_pend_r, halted_r;
  logic              run_s, pop_s, redir_s, stop_s, issue_s, push_s, fpop_s;
  logic [1:0]        fifo_count_s;
  logic [ENT_W-1:0]  head_s;

  // handshake, redirect/halt priority and issue decision
  always_comb begin
    run_s   = (state_r == ST_RUN);
    pop_s   = if_valid & id_ready;
    redir_s = run_s & redirect & ~halt_pend_r;
    stop_s  = run_s & ~redir_s & (halt | halt_pend_r);
    issue_s = run_s & ~redir_s & ~stop_s & issue_ok(fifo_count_s, inflight_r, pop_s);
    push_s  = inflight_r & ~redir_s;
    fpop_s  = pop_s & ~redir_s;
  end

  // FSM next state and PC update
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = ST_RUN;
      ST_RUN: begin
        if (stop_s && (fifo_count_s == 2'd0) && !inflight_r) state_s = ST_HALTED;
        else                                                  state_s = ST_RUN;
      end
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_IDLE;
    endcase
    if (redir_s)      pc_s = redirect_pc;
    else if (issue_s) pc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    else              pc_s = pc_r;
  end

  // state, PC and in-flight tracking; a redirect leaves nothing in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
      halt_pend_r   <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      inflight_r  <= issue_s;
      halt_pend_r <= halt_pend_r | stop_s;
      halted_r    <= (state_s == ST_HALTED);
      if (issue_s) inflight_pc_r <= pc_r;
      else         inflight_pc_r <= inflight_pc_r;
    end
  end

  fetch_unit_fifo2 #(.W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redir_s),
    .push  (push_s),
    .pop   (fpop_s),
    .wdata ({inflight_pc_r, imem_rdata}),
    .head  (head_s),
    .count (fifo_count_s)
  );

  assign imem_en   = issue_s;
  assign imem_addr = pc_r;
  assign if_valid  = (fifo_count_s != 2'd0);
  assign if_pc     = head_s[ENT_W-1:INSTR_W];
  assign if_instr  = head_s[INSTR_W-1:0];
  assign halted    = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table, scoreboard of delivered
// words, and hand sequences for wrap and mid-stream reset.
module tb_fetch_unit;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'd0;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [AW-1:0] if_pc;
  logic          id_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          halted;

  int n_tests = 0;
  int n_fail  = 0;
  int nacc    = 0;
  int exp_q[$];

  typedef struct {
    logic          rdy;
    logic          redir;
    logic [AW-1:0] rpc;
    logic          hlt;
    logic          sb_re;
    logic          en;
    logic [AW-1:0] addr;
    logic          vld;
    logic [AW-1:0] pc;
    logic          hd;
  } vec_t;

  vec_t vt[29];

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  // instruction memory: mem[k] = k + 100, one-cycle read latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'(imem_addr) + 32'd100;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_load(input int start, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back((start + k) % (1 << AW));
  endtask

  task automatic wait_acc(input int n, input string name);
    int cyc = 0;
    while (nacc < n && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    chk(name, 32'(nacc >= n), 32'd1);
  endtask

  function automatic vec_t v(input logic rdy, input logic redir, input int rpc, input logic hlt,
                             input logic sb_re, input logic en, input int addr, input logic vld,
                             input int pc, input logic hd);
    vec_t r;
    r.rdy = rdy; r.redir = redir; r.rpc = AW'(rpc); r.hlt = hlt; r.sb_re = sb_re;
    r.en = en; r.addr = AW'(addr); r.vld = vld; r.pc = AW'(pc); r.hd = hd;
    return r;
  endfunction

  // scoreboard: every accepted word must be the next expected pc with mem[pc]
  always @(negedge clk) begin : mon
    int e;
    if (rst && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got pc %0d, expected no delivery", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", 32'(if_pc), 32'(e));
        chk("sb_instr", if_instr, 32'(e) + 32'd100);
        nacc++;
      end
    end
    if (rst) chk("no_overflow",
                 32'(dut.u_fifo.push && !dut.u_fifo.pop && (dut.u_fifo.count_r == 2'd2)), 32'd0);
  end

  initial begin
    // rdy redir rpc hlt sbre | en addr vld pc hd
    vt[0] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vt[1] = v(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int k = 2; k < 10; k++) vt[k] = v(1, 0, 0, 0, 0, 1, k, 1, k - 2, 0);
    for (int k = 10; k < 15; k++) vt[k] = v(0, 0, 0, 0, 0, 0, 10, 1, 8, 0);
    vt[15] = v(1, 0, 0, 0, 0, 1, 10, 1, 8, 0);
    vt[16] = v(1, 0, 0, 0, 0, 1, 11, 1, 9, 0);
    vt[17] = v(1, 0, 0, 0, 0, 1, 12, 1, 10, 0);
    vt[18] = v(0, 1, 40, 0, 1, 0, 13, 1, 11, 0);
    vt[19] = v(1, 0, 0, 0, 0, 1, 40, 0, 0, 0);
    vt[20] = v(1, 0, 0, 0, 0, 1, 41, 0, 0, 0);
    vt[21] = v(1, 0, 0, 0, 0, 1, 42, 1, 40, 0);
    vt[22] = v(1, 0, 0, 0, 0, 1, 43, 1, 41, 0);
    vt[23] = v(0, 0, 0, 0, 0, 0, 44, 1, 42, 0);
    vt[24] = v(1, 0, 0, 1, 0, 0, 44, 1, 42, 0);
    vt[25] = v(1, 1, 7, 0, 0, 0, 44, 1, 43, 0);
    vt[26] = v(1, 0, 0, 0, 0, 0, 44, 0, 0, 0);
    vt[27] = v(1, 1, 5, 0, 0, 0, 44, 0, 0, 1);
    vt[28] = v(1, 0, 0, 0, 0, 0, 44, 0, 0, 1);

    sb_load(0, 64);
    #2;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    #8 rst = 1'b1;

    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      #1;
      id_ready    = vt[i].rdy;
      redirect    = vt[i].redir;
      redirect_pc = vt[i].rpc;
      halt        = vt[i].hlt;
      if (vt[i].sb_re) sb_load(int'(vt[i].rpc), 64);
      #2;
      chk($sformatf("row%0d_en", i), 32'(imem_en), 32'(vt[i].en));
      chk($sformatf("row%0d_addr", i), 32'(imem_addr), 32'(vt[i].addr));
      chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(vt[i].vld));
      if (vt[i].vld) begin
        chk($sformatf("row%0d_pc", i), 32'(if_pc), 32'(vt[i].pc));
        chk($sformatf("row%0d_instr", i), if_instr, 32'(vt[i].pc) + 32'd100);
      end
      chk($sformatf("row%0d_halted", i), 32'(halted), 32'(vt[i].hd));
    end
    chk("table_accepts", 32'(nacc), 32'd15);

    // leave HALTED through reset and restart from RESET_PC
    @(posedge clk);
    #1;
    rst = 1'b0; id_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
    #1;
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_valid", 32'(if_valid), 32'd0);
    sb_load(0, 64);
    nacc = 0;
    @(negedge clk);
    rst = 1'b1;
    id_ready = 1'b1;
    wait_acc(3, "restart_acc");

    // wrap: redirect to the last word address, next word must be pc 0
    @(posedge clk);
    #1;
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = '1;
    sb_load((1 << AW) - 1, 16);
    @(posedge clk);
    #1;
    redirect = 1'b0; id_ready = 1'b1; nacc = 0;
    wait_acc(4, "wrap_acc");

    // asynchronous reset mid-stream
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_en", 32'(imem_en), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    sb_load(0, 64);
    nacc = 0;
    @(negedge clk);
    rst = 1'b1;
    wait_acc(5, "post_rst_acc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
